// File: rtl/moduli_term_accumulator.sv
// rtl/moduli_term_accumulator.sv - carry-save accumulator of moduli terms with segmented carry-propagate resolve
module moduli_term_accumulator #(
    parameter int MODULUS_WIDTH = 1024,
    parameter int GUARD_BITS    = 8,
    parameter int SEG_WIDTH     = 64,
    localparam int ACC_WIDTH    = MODULUS_WIDTH + GUARD_BITS,
    localparam int NUM_SEG      = (ACC_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH
) (
    input  logic                     clk_phase,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [MODULUS_WIDTH-1:0] in_base,
    input  logic [MODULUS_WIDTH-1:0] in_terms [3],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_result,
    output logic                     protocol_err
);

    localparam int PAD_WIDTH = NUM_SEG * SEG_WIDTH;
    localparam int CNT_W     = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESOLVE, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ACC_WIDTH-1:0]   r_sum;
    logic [ACC_WIDTH-1:0]   r_carry;
    logic [ACC_WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]       r_seg;
    logic                   r_cin;
    logic                   r_perr;

    logic                   w_accept;
    logic                   w_load;
    logic                   w_add;
    logic                   w_err;
    logic [ACC_WIDTH-1:0]   w_op_a, w_op_b;
    logic [ACC_WIDTH-1:0]   w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;
    logic [SEG_WIDTH-1:0]   w_sum_seg, w_carry_seg;
    logic [SEG_WIDTH:0]     w_seg_total;
    logic [ACC_WIDTH-1:0]   w_seg_mask;
    logic [ACC_WIDTH-1:0]   w_seg_bits;
    logic [ACC_WIDTH-1:0]   w_result_next;
    int                     w_shamt;

    // One 3:2 stage; the carry vector is shifted left and its MSB falls off.
    function automatic logic [2*ACC_WIDTH-1:0] csa3(
        input logic [ACC_WIDTH-1:0] a,
        input logic [ACC_WIDTH-1:0] b,
        input logic [ACC_WIDTH-1:0] c
    );
        logic [ACC_WIDTH-1:0] s;
        logic [ACC_WIDTH-1:0] cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {s, cy};
    endfunction

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk_phase) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_load    = 1'b0;
        w_add     = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (in_first) begin
                        w_load = 1'b1;
                        w_next = in_last ? S_RESOLVE : S_ACCUM;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (in_first) begin
                        w_err  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_add = 1'b1;
                    end
                    if (in_last) begin
                        w_next = S_RESOLVE;
                    end
                end
            end
            S_RESOLVE: begin
                if (r_seg == CNT_W'(NUM_SEG - 1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A first beat replaces the redundant pair with {base, 0}.
    assign w_op_a = w_load ? ACC_WIDTH'(in_base) : r_sum;
    assign w_op_b = w_load ? '0 : r_carry;

    assign {w_s1, w_c1} = csa3(w_op_a, w_op_b, ACC_WIDTH'(in_terms[0]));
    assign {w_s2, w_c2} = csa3(w_s1, w_c1, ACC_WIDTH'(in_terms[1]));
    assign {w_s3, w_c3} = csa3(w_s2, w_c2, ACC_WIDTH'(in_terms[2]));

    assign w_shamt     = int'(r_seg) * SEG_WIDTH;
    assign w_sum_seg   = SEG_WIDTH'(PAD_WIDTH'(r_sum) >> w_shamt);
    assign w_carry_seg = SEG_WIDTH'(PAD_WIDTH'(r_carry) >> w_shamt);
    assign w_seg_total = {1'b0, w_sum_seg} + {1'b0, w_carry_seg} + {{SEG_WIDTH{1'b0}}, r_cin};

    // Bits of the last segment beyond ACC_WIDTH are truncated away here.
    assign w_seg_mask    = ACC_WIDTH'(PAD_WIDTH'({SEG_WIDTH{1'b1}}) << w_shamt);
    assign w_seg_bits    = ACC_WIDTH'(PAD_WIDTH'(w_seg_total[SEG_WIDTH-1:0]) << w_shamt);
    assign w_result_next = (r_result & ~w_seg_mask) | w_seg_bits;

    always_ff @(posedge clk_phase) begin
        if (reset) begin
            r_sum    <= '0;
            r_carry  <= '0;
            r_result <= '0;
            r_seg    <= '0;
            r_cin    <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_perr <= w_err;
            if (w_load || w_add) begin
                r_sum   <= w_s3;
                r_carry <= w_c3;
            end
            if (r_state == S_RESOLVE) begin
                r_result <= w_result_next;
                r_cin    <= w_seg_total[SEG_WIDTH];
                r_seg    <= (r_seg == CNT_W'(NUM_SEG - 1)) ? '0 : r_seg + 1'b1;
            end else begin
                r_seg <= '0;
                r_cin <= 1'b0;
            end
        end
    end

    assign out_result   = r_result;
    assign protocol_err = r_perr;

endmodule
